serial_compare_driver: RTL and testbench

- Parallel-to-serial front end for the bit-serial magnitude comparator FSM.
- Accepts two WIDTH-bit operands through a valid/ready handshake and clears the comparator.
- Streams the operand bit pairs to the comparator with a last-bit strobe, then captures the comparator's L/E/G verdict and returns it as a registered, one-hot result.
- Sits between a parallel datapath and the comparator, which is instantiated beside it.

---
 rtl/serial_compare_driver_pkg.sv | 37 +++
 rtl/serial_compare_driver_piso.sv | 46 ++++
 rtl/serial_compare_driver.sv | 130 +++++++++++++
 tb/tb_serial_compare_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_compare_driver_pkg.sv
// Shared definitions for the serial comparator driver and other consumers of the
// comparator's L/E/G verdict.
package serial_compare_driver_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    SHIFT   = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RES_LT  = 2'd0,
    RES_EQ  = 2'd1,
    RES_GT  = 2'd2,
    RES_ERR = 2'd3
  } res_code_e;

  function automatic logic lge_not_onehot(input logic l, input logic e, input logic g);
    return (({1'b0, l} + {1'b0, e} + {1'b0, g}) != 2'd1);
  endfunction

  function automatic res_code_e res_code(input logic l, input logic e, input logic g);
    res_code_e code;
    if (lge_not_onehot(l, e, g)) begin
      code = RES_ERR;
    end else if (l) begin
      code = RES_LT;
    end else if (e) begin
      code = RES_EQ;
    end else begin
      code = RES_GT;
    end
    return code;
  endfunction

endpackage

// File: rtl/serial_compare_driver_piso.sv
// Pair of parallel-load shift registers presenting one bit of each operand per cycle.
module piso_pair
  import serial_compare_driver_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             bit_a,
  output logic             bit_b
);

  logic [WIDTH-1:0] sr_a;
  logic [WIDTH-1:0] sr_b;

  // Load both operands together, then advance both in lockstep toward the output end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_a <= '0;
      sr_b <= '0;
    end else if (load) begin
      sr_a <= a_in;
      sr_b <= b_in;
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        sr_a <= {sr_a[WIDTH-2:0], 1'b0};
        sr_b <= {sr_b[WIDTH-2:0], 1'b0};
      end else begin
        sr_a <= {1'b0, sr_a[WIDTH-1:1]};
        sr_b <= {1'b0, sr_b[WIDTH-1:1]};
      end
    end else begin
      sr_a <= sr_a;
      sr_b <= sr_b;
    end
  end

  assign bit_a = (MSB_FIRST != 0) ? sr_a[WIDTH-1] : sr_a[0];
  assign bit_b = (MSB_FIRST != 0) ? sr_b[WIDTH-1] : sr_b[0];

endmodule

// File: rtl/serial_compare_driver.sv
// Front end that serialises an operand pair into the bit-serial magnitude comparator
// and returns its captured L/E/G verdict as a registered one-hot result.
module serial_compare_driver
  import serial_compare_driver_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             in_ready,
  output logic             cmp_rst,
  output logic             cmp_op,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_L,
  input  logic             cmp_E,
  input  logic             cmp_G,
  output logic             res_valid,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_gt,
  output logic             res_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state;
  state_e        next_state;
  logic [CW-1:0] cnt;
  logic          load;
  logic          shift;

  piso_pair #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .a_in  (in_a),
    .b_in  (in_b),
    .bit_a (cmp_a),
    .bit_b (cmp_b)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus shifter control; the last bit is not shifted out so CAPTURE holds it.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          next_state = CLEAR;
        end else begin
          next_state = IDLE;
        end
      end
      CLEAR: begin
        next_state = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) begin
          next_state = CAPTURE;
        end else begin
          shift = 1'b1;
        end
      end
      CAPTURE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Bit counter: cleared on accept, advanced through SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if ((state == SHIFT) && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= cnt;
    end
  end

  // Result capture at the close of CAPTURE; values persist until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_lt    <= 1'b0;
      res_eq    <= 1'b0;
      res_gt    <= 1'b0;
      res_err   <= 1'b0;
    end else if (state == CAPTURE) begin
      res_valid <= 1'b1;
      res_lt    <= cmp_L;
      res_eq    <= cmp_E;
      res_gt    <= cmp_G;
      res_err   <= lge_not_onehot(cmp_L, cmp_E, cmp_G);
    end else begin
      res_valid <= 1'b0;
    end
  end

  assign in_ready = (state == IDLE);
  assign cmp_rst  = (state == IDLE) || (state == CLEAR);
  assign cmp_op   = (state == SHIFT) && (cnt == LAST);

endmodule

// File: tb/tb_serial_compare_driver.sv
// Drives an LSB-first and an MSB-first driver side by side, each wired to a behavioural
// bit-serial comparator, and checks streams and results against operand arithmetic.
module tb_serial_compare_driver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         force_bad;

  logic [1:0] in_ready, cmp_rst, cmp_op, cmp_a, cmp_b, cmp_L, cmp_E, cmp_G;
  logic [1:0] res_valid, res_lt, res_eq, res_gt, res_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic prev_lt = 1'b0, prev_eq = 1'b0, prev_gt = 1'b0, prev_err = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : inst
    logic [W-1:0] sa, sb;
    int           scnt;
    logic         sdone;

    serial_compare_driver #(.WIDTH(W), .MSB_FIRST(g)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .in_ready(in_ready[g]), .cmp_rst(cmp_rst[g]), .cmp_op(cmp_op[g]),
      .cmp_a(cmp_a[g]), .cmp_b(cmp_b[g]),
      .cmp_L(cmp_L[g]), .cmp_E(cmp_E[g]), .cmp_G(cmp_G[g]),
      .res_valid(res_valid[g]), .res_lt(res_lt[g]), .res_eq(res_eq[g]),
      .res_gt(res_gt[g]), .res_err(res_err[g])
    );

    // Comparator stand-in: collects the serial bits and reports after the op bit.
    always @(posedge clk) begin
      if (cmp_rst[g]) begin
        sa    <= '0;
        sb    <= '0;
        scnt  <= 0;
        sdone <= 1'b0;
      end else if (!sdone && scnt < W) begin
        sa[(g != 0) ? (W - 1 - scnt) : scnt] <= cmp_a[g];
        sb[(g != 0) ? (W - 1 - scnt) : scnt] <= cmp_b[g];
        scnt <= scnt + 1;
        if (cmp_op[g]) sdone <= 1'b1;
      end
    end

    assign cmp_L[g] = sdone & (force_bad | (sa < sb));
    assign cmp_E[g] = sdone & ~force_bad & (sa == sb);
    assign cmp_G[g] = sdone & (force_bad | (sa > sb));
  end

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
  endtask

  // Follows one operation from the cycle after its accept edge to its res_valid cycle.
  task automatic watch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bad);
    logic xl, xe, xg;
    int   k, idx;
    xl = bad | (a < b);
    xe = ~bad & (a == b);
    xg = bad | (a > b);
    for (int n = 1; n <= W + 3; n++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (n == 1) begin
          check_eq($sformatf("clear_rst%0d", g), cmp_rst[g], 1'b1);
          check_eq($sformatf("clear_op%0d", g), cmp_op[g], 1'b0);
          check_eq($sformatf("clear_rv%0d", g), res_valid[g], 1'b0);
          check_eq($sformatf("hold_lt%0d", g), res_lt[g], prev_lt);
          check_eq($sformatf("hold_eq%0d", g), res_eq[g], prev_eq);
          check_eq($sformatf("hold_gt%0d", g), res_gt[g], prev_gt);
          check_eq($sformatf("hold_err%0d", g), res_err[g], prev_err);
        end else if (n <= W + 1) begin
          k   = n - 2;
          idx = (g != 0) ? (W - 1 - k) : k;
          check_eq($sformatf("shift_rst%0d_k%0d", g, k), cmp_rst[g], 1'b0);
          check_eq($sformatf("bit_a%0d_k%0d", g, k), cmp_a[g], a[idx]);
          check_eq($sformatf("bit_b%0d_k%0d", g, k), cmp_b[g], b[idx]);
          check_eq($sformatf("op%0d_k%0d", g, k), cmp_op[g], k == W - 1);
        end else if (n == W + 2) begin
          idx = (g != 0) ? 0 : W - 1;
          check_eq($sformatf("cap_rst%0d", g), cmp_rst[g], 1'b0);
          check_eq($sformatf("cap_op%0d", g), cmp_op[g], 1'b0);
          check_eq($sformatf("cap_a%0d", g), cmp_a[g], a[idx]);
          check_eq($sformatf("cap_b%0d", g), cmp_b[g], b[idx]);
          check_eq($sformatf("cap_rv%0d", g), res_valid[g], 1'b0);
        end else begin
          check_eq($sformatf("res_valid%0d", g), res_valid[g], 1'b1);
          check_eq($sformatf("res_lt%0d", g), res_lt[g], xl);
          check_eq($sformatf("res_eq%0d", g), res_eq[g], xe);
          check_eq($sformatf("res_gt%0d", g), res_gt[g], xg);
          check_eq($sformatf("res_err%0d", g), res_err[g], bad);
        end
        check_eq($sformatf("ready%0d_n%0d", g, n), in_ready[g], n == W + 3);
      end
    end
    prev_lt  = xl;
    prev_eq  = xe;
    prev_gt  = xg;
    prev_err = bad;
  endtask

  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic bad);
    accept(a, b);
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    watch(a, b, bad);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    force_bad = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("rst_ready%0d", g), in_ready[g], 1'b1);
      check_eq($sformatf("rst_cmp_rst%0d", g), cmp_rst[g], 1'b1);
      check_eq($sformatf("rst_op%0d", g), cmp_op[g], 1'b0);
      check_eq($sformatf("rst_a%0d", g), cmp_a[g], 1'b0);
      check_eq($sformatf("rst_b%0d", g), cmp_b[g], 1'b0);
      check_eq($sformatf("rst_rv%0d", g), res_valid[g], 1'b0);
      check_eq($sformatf("rst_res%0d", g), res_lt[g] | res_eq[g] | res_gt[g] | res_err[g], 1'b0);
    end
    rst = 1'b0;

    single(4'b0101, 4'b0110, 1'b0);
    single(4'b1001, 4'b1001, 1'b0);
    single(4'b1000, 4'b0111, 1'b0);

    // Back-to-back: second pair is accepted in the res_valid cycle of the first.
    accept(4'b0011, 4'b1100);
    in_a = 4'b1111;
    in_b = 4'b1111;
    watch(4'b0011, 4'b1100, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
    watch(4'b1111, 4'b1111, 1'b0);

    // Abort mid-SHIFT, after bit 2 has been presented.
    accept(4'b0110, 4'b0101);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("abort_ready%0d", g), in_ready[g], 1'b1);
      check_eq($sformatf("abort_cmp_rst%0d", g), cmp_rst[g], 1'b1);
      check_eq($sformatf("abort_op%0d", g), cmp_op[g], 1'b0);
      check_eq($sformatf("abort_a%0d", g), cmp_a[g] | cmp_b[g], 1'b0);
      check_eq($sformatf("abort_rv%0d", g), res_valid[g], 1'b0);
      check_eq($sformatf("abort_res%0d", g), res_lt[g] | res_eq[g] | res_gt[g] | res_err[g], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid != 2'b00) seen = 1'b1;
    end
    check_eq("abort_no_rv", seen, 1'b0);
    prev_lt  = 1'b0;
    prev_eq  = 1'b0;
    prev_gt  = 1'b0;
    prev_err = 1'b0;
    single(4'b0110, 4'b0101, 1'b0);

    // Comparator reporting L and G together.
    force_bad = 1'b1;
    single(4'b0010, 4'b0010, 1'b1);
    force_bad = 1'b0;

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      single(ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
